// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction loader: instruction field positions,
// loader error codes and the loader FSM state type.
package isa_pkg;

    localparam int unsigned OP_HI_MSB = 15;
    localparam int unsigned OP_HI_LSB = 12;
    localparam int unsigned RDEST_MSB = 11;
    localparam int unsigned RDEST_LSB = 8;
    localparam int unsigned OPEXT_MSB = 7;
    localparam int unsigned OPEXT_LSB = 4;
    localparam int unsigned RSRC_MSB  = 3;
    localparam int unsigned RSRC_LSB  = 0;
    localparam int unsigned IMM8_MSB  = 7;
    localparam int unsigned IMM8_LSB  = 0;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_IMM    = 2'd1;
    localparam logic [1:0] ERR_VERIFY = 2'd2;
    localparam logic [1:0] ERR_OVF    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StWrite,
        StRead,
        StCheck,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into the 16-bit word the fetch-path decoder consumes,
// and flags immediates that do not fit the 8-bit signed field.
module instr_encoder
    import isa_pkg::*;
(
    input  logic [7:0]  opcode,
    input  logic [3:0]  rdest,
    input  logic [3:0]  rsrc,
    input  logic [15:0] imm_in,
    input  logic        imm_form,
    output logic [15:0] word,
    output logic        imm_ok
);

    always_comb begin
        word = '0;
        word[OP_HI_MSB:OP_HI_LSB] = opcode[7:4];
        word[RDEST_MSB:RDEST_LSB] = rdest;
        if (imm_form) begin
            word[IMM8_MSB:IMM8_LSB] = imm_in[7:0];
        end else begin
            word[OPEXT_MSB:OPEXT_LSB] = opcode[3:0];
            word[RSRC_MSB:RSRC_LSB]   = rsrc;
        end
    end

    // Upper byte must be a pure sign extension of bit 7; register form ignores imm_in.
    assign imm_ok = !imm_form || (imm_in[15:8] == {8{imm_in[7]}});

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: accepts one instruction per handshake, packs it, writes it,
// reads it back and verifies it, advancing the address until the last word of the session.
module instr_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [7:0]        opcode,
    input  logic [3:0]        rdest,
    input  logic [3:0]        rsrc,
    input  logic [15:0]       imm_in,
    input  logic              imm_form,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;

    logic [15:0] enc_word;
    logic        enc_imm_ok;

    instr_encoder u_encoder (
        .opcode   (opcode),
        .rdest    (rdest),
        .rsrc     (rsrc),
        .imm_in   (imm_in),
        .imm_form (imm_form),
        .word     (enc_word),
        .imm_ok   (enc_imm_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            count_q <= count_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        last_d  = last_q;
        count_d = count_q;
        error_d = error_q;
        code_d  = code_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    error_d = 1'b0;
                    code_d  = ERR_NONE;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                if (in_valid) begin
                    word_d = enc_word;
                    last_d = in_last;
                    if (!enc_imm_ok) begin
                        error_d = 1'b1;
                        code_d  = ERR_IMM;
                        state_d = StError;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: state_d = StRead;
            StRead:  state_d = StCheck;
            StCheck: begin
                if (mem_rdata != word_q) begin
                    error_d = 1'b1;
                    code_d  = ERR_VERIFY;
                    state_d = StError;
                end else begin
                    count_d = count_q + 1'b1;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (addr_q == LAST_ADDR) begin
                        // Out of address space before the host said "last": stop, never wrap.
                        error_d = 1'b1;
                        code_d  = ERR_OVF;
                        state_d = StError;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StAccept;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign in_ready   = (state_q == StAccept);
    assign mem_we     = (state_q == StWrite);
    assign mem_re     = (state_q == StRead);
    assign mem_addr   = addr_q;
    assign mem_wdata  = word_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign error      = error_q;
    assign err_code   = code_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes and session outcomes are queued by the
// stimulus from a reference model; a negedge monitor pops and compares them.
module tb_instr_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [7:0]        opcode = '0;
    logic [3:0]        rdest = '0;
    logic [3:0]        rsrc = '0;
    logic [15:0]       imm_in = '0;
    logic              imm_form = 1'b0;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata = '0;
    logic              busy, done, error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .opcode     (opcode),
        .rdest      (rdest),
        .rsrc       (rsrc),
        .imm_in     (imm_in),
        .imm_form   (imm_form),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        int         count;
    } end_t;

    wr_t  exp_wr[$];
    end_t exp_end[$];

    // Memory model; flip corrupts bit 0 of every readback.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    bit          flip = 1'b0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr] ^ {15'b0, flip};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    wr_t  mon_w;
    end_t mon_e;
    logic error_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(mon_w.addr));
                    chk("wr_data", 64'(mem_wdata), 64'(mon_w.data));
                end
            end
            if (done || (error && !error_prev)) begin
                if (exp_end.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: got done %0b error %0b expected none",
                             done, error);
                end else begin
                    mon_e = exp_end.pop_front();
                    chk("end_is_err", 64'(error), 64'(mon_e.is_err));
                    chk("end_done", 64'(done), 64'(!mon_e.is_err));
                    chk("end_code", 64'(err_code), 64'(mon_e.code));
                    chk("end_count", 64'(word_count), 64'(mon_e.count));
                end
            end
        end
        error_prev <= error;
    end

    // Reference model helpers
    function automatic logic [15:0] pack(input logic [7:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic [15:0] imm,
                                         input bit form);
        return form ? {op[7:4], rd, imm[7:0]} : {op[7:4], rd, op[3:0], rs};
    endfunction

    function automatic bit imm_fits(input logic [15:0] imm);
        int v;
        v = int'($signed(imm));
        return (v >= -128) && (v <= 127);
    endfunction

    logic [7:0]  s_op   [8];
    logic [3:0]  s_rd   [8];
    logic [3:0]  s_rs   [8];
    logic [15:0] s_imm  [8];
    bit          s_form [8];
    bit          s_last [8];

    task automatic set_instr(input int i, input logic [7:0] op, input logic [3:0] rd,
                             input logic [3:0] rs, input logic [15:0] imm, input bit form,
                             input bit last);
        s_op[i] = op; s_rd[i] = rd; s_rs[i] = rs; s_imm[i] = imm;
        s_form[i] = form; s_last[i] = last;
    endtask

    task automatic outputs_zero(input string name);
        chk(name, {in_ready, mem_we, mem_re, mem_addr, mem_wdata, busy, done, error, err_code,
                   word_count}, 64'd0);
    endtask

    task automatic run_session(input logic [ADDR_W-1:0] base, input int n, input bit gaps);
        logic [ADDR_W-1:0] maddr;
        int                mcount;
        bit                ended;
        logic [15:0]       w;
        int                gap;
        maddr  = base;
        mcount = 0;
        ended  = 1'b0;
        @(posedge clk); #1 start = 1'b1; base_addr = base;
        @(posedge clk); #1 start = 1'b0; base_addr = 10'($urandom);
        chk("ready_after_start", 64'(in_ready), 64'd1);
        chk("cleared_on_start", {busy, error, err_code, word_count}, {1'b1, 14'd0});
        for (int i = 0; i < n && !ended; i++) begin
            gap = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gap; g++) begin
                // Stray start pulses while busy must be ignored.
                start = 1'b1;
                base_addr = 10'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            chk("ready_before_accept", 64'(in_ready), 64'd1);
            in_valid = 1'b1; opcode = s_op[i]; rdest = s_rd[i]; rsrc = s_rs[i];
            imm_in = s_imm[i]; imm_form = s_form[i]; in_last = s_last[i];
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0; opcode = 8'($urandom); imm_in = 16'($urandom);
            if (s_form[i] && !imm_fits(s_imm[i])) begin
                exp_end.push_back('{1'b1, 2'd1, mcount});
                ended = 1'b1;
                chk("imm_err_at_a1", {error, mem_we}, {1'b1, 1'b0});
            end else begin
                w = pack(s_op[i], s_rd[i], s_rs[i], s_imm[i], s_form[i]);
                exp_wr.push_back('{maddr, w});
                chk("we_at_a1", 64'(mem_we), 64'd1);
                @(posedge clk); #1;
                chk("re_at_a2", {mem_re, mem_addr}, {1'b1, maddr});
                @(posedge clk); #1;
                @(posedge clk); #1;
                if (flip) begin
                    exp_end.push_back('{1'b1, 2'd2, mcount});
                    ended = 1'b1;
                    chk("verify_err_at_a4", 64'(error), 64'd1);
                end else begin
                    mcount++;
                    if (s_last[i]) begin
                        exp_end.push_back('{1'b0, 2'd0, mcount});
                        ended = 1'b1;
                        chk("done_at_a4", 64'(done), 64'd1);
                    end else if (maddr == 10'h3FF) begin
                        exp_end.push_back('{1'b1, 2'd3, mcount});
                        ended = 1'b1;
                        chk("ovf_err_at_a4", 64'(error), 64'd1);
                    end else begin
                        maddr = maddr + 10'd1;
                        chk("ready_at_a4", 64'(in_ready), 64'd1);
                    end
                end
                chk("word_count_a4", 64'(word_count), 64'(mcount));
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_after_session", 64'(busy), 64'd0);
    endtask

    task automatic reset_mid_write();
        @(posedge clk); #1 start = 1'b1; base_addr = 10'h055;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1; opcode = 8'h12; rdest = 4'h1; rsrc = 4'h2; imm_form = 1'b0;
        in_last = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
        chk("we_before_reset", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1 outputs_zero("reset_mid_write");
        @(posedge clk); #1 rst_n = 1'b1;
        chk("idle_after_reset", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        logic [ADDR_W-1:0] base;
        #2 outputs_zero("reset_values");
        @(posedge clk); #1 rst_n = 1'b1;
        outputs_zero("after_reset_release");

        // Register form
        set_instr(0, 8'h05, 4'd3, 4'd7, 16'h0000, 1'b0, 1'b1);
        run_session(10'h010, 1, 1'b0);
        chk("reg_word_in_mem", 64'(mem[10'h010]), 64'h0357);

        // Immediate form, in range then out of range
        set_instr(0, 8'h50, 4'd2, 4'd0, 16'hFFF6, 1'b1, 1'b1);
        run_session(10'h020, 1, 1'b0);
        chk("imm_word_in_mem", 64'(mem[10'h020]), 64'h52F6);
        set_instr(0, 8'h50, 4'd2, 4'd0, 16'h0100, 1'b1, 1'b1);
        run_session(10'h021, 1, 1'b0);
        chk("imm_err_code", {error, err_code}, {1'b1, 2'd1});

        // Three-word burst with gaps and ignored stray starts
        set_instr(0, 8'hA3, 4'd1, 4'd4, 16'h0000, 1'b0, 1'b0);
        set_instr(1, 8'h7C, 4'd9, 4'd0, 16'h007F, 1'b1, 1'b0);
        set_instr(2, 8'h3E, 4'd15, 4'd8, 16'hFF80, 1'b1, 1'b1);
        run_session(10'h100, 3, 1'b1);
        chk("burst_count", 64'(word_count), 64'd3);

        // Readback corruption, then recovery on next start
        flip = 1'b1;
        set_instr(0, 8'h11, 4'd5, 4'd6, 16'h0000, 1'b0, 1'b1);
        run_session(10'h200, 1, 1'b0);
        chk("verify_err_code", {error, err_code, word_count}, {1'b1, 2'd2, 11'd0});
        flip = 1'b0;
        run_session(10'h201, 1, 1'b0);

        // Address overflow without wrap
        set_instr(0, 8'h22, 4'd1, 4'd1, 16'h0000, 1'b0, 1'b0);
        set_instr(1, 8'h33, 4'd2, 4'd2, 16'h0000, 1'b0, 1'b0);
        run_session(10'h3FF, 2, 1'b0);
        chk("ovf_err_code", {error, err_code, word_count}, {1'b1, 2'd3, 11'd1});

        reset_mid_write();

        // Randomized sessions
        for (int s = 0; s < 25; s++) begin
            n = int'($urandom_range(1, 5));
            base = ($urandom_range(0, 3) == 0) ? 10'(10'h3FF - $urandom_range(0, 2))
                                               : 10'($urandom);
            flip = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < n; i++) begin
                set_instr(i, 8'($urandom), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 4) == 0) ? 16'($urandom)
                                                      : {{8{1'($urandom)}}, 8'($urandom)},
                          1'($urandom), i == n - 1);
            end
            run_session(base, n, 1'b1);
        end
        flip = 1'b0;

        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("end_queue_drained", 64'(exp_end.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writes a program into instruction memory, one instruction per handshake. Each instruction arrives as decoded fields (8-bit opcode, Rdest, Rsrc, immediate, form flag) and is packed into the 16-bit instruction word the CPU decoder consumes. The word is then written to memory, read back and compared. The block sits between a host or boot source and the instruction memory port, and acts as the encoder/writer for the decoder in the fetch path.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory address width; last address is 2**ADDR_W-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; honoured only in IDLE
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts fields this cycle
- in_last  in  1  marks the final instruction of the session
- opcode  in  8  {op[3:0], opext[3:0]}
- rdest  in  4  destination register field
- rsrc  in  4  source register field
- imm_in  in  16  immediate, signed
- imm_form  in  1  1 = immediate format, 0 = register format
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  16  packed instruction word
- mem_rdata  in  16  read data, valid one cycle after mem_re
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful session end
- error  out  1  sticky; cleared by the next accepted start
- err_code  out  2  0 none, 1 imm range, 2 verify mismatch, 3 address overflow
- word_count  out  ADDR_W+1  words verified this session

## Operation
- Packing:
  - register form: word = {opcode[7:4], rdest, opcode[3:0], rsrc}
  - immediate form: word = {opcode[7:4], rdest, imm_in[7:0]}
- Imm range check, immediate form only: imm_in[15:8] must all equal imm_in[7]; otherwise err_code 1. In register form imm_in is ignored.
- FSM states: IDLE, ACCEPT, WRITE, READ, CHECK, DONE, ERROR.
  - IDLE: on start, latch base_addr into the address register, clear word_count, error and err_code, go to ACCEPT.
  - ACCEPT: in_ready=1. On in_valid, latch word and in_last. Range failure goes to ERROR (code 1); otherwise go to WRITE.
  - WRITE: mem_we=1, mem_addr=addr, mem_wdata=word; go to READ.
  - READ: mem_re=1, same address; go to CHECK.
  - CHECK: compare mem_rdata with word.
    - Mismatch: ERROR, code 2.
    - Match, last set: word_count+1, go to DONE.
    - Match, last clear, addr = 2**ADDR_W-1: word_count+1, ERROR code 3; no wrap.
    - Otherwise: word_count+1, addr+1, go to ACCEPT.
  - DONE: done=1, then IDLE.
  - ERROR: error=1 and err_code set, then IDLE; both hold until the next start.
- start outside IDLE is ignored. in_valid outside ACCEPT is ignored (no accept).
- Reset mid-session: everything returns to reset values immediately. Memory contents already written are left as is.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, busy 0, done 0, error 0, err_code 0, word_count 0.
- All outputs are registered or decoded from state (Moore); no combinational path from in_valid to in_ready.
- start at cycle t: in_ready high at t+1.
- Accept at cycle a:
  - mem_we at a+1, mem_re at a+2, compare at a+3.
  - a+4: in_ready high again, or done high, or error high.
- Throughput: one word per 4 cycles. Word error detected in ACCEPT shows error at a+1.
- word_count updates at the end of the CHECK cycle.

## Structure
- Package isa_pkg holds:
  - field positions (OP_HI 15:12, RDEST 11:8, OPEXT 7:4, RSRC 3:0, IMM8 7:0)
  - ERR_NONE/ERR_IMM/ERR_VERIFY/ERR_OVF constants
  - the loader state enum
- Sub-module instr_encoder: combinational packing plus range check, outputs {word, imm_ok}. The decoder's tests can reuse it as a golden model.

## Test plan
- Register form: base 0x010, opcode 0x05, rdest 3, rsrc 7, last → write 0x0357 @0x010, readback match, done pulse, word_count 1.
- Immediate form: opcode 0x50, rdest 2, imm 0xFFF6 → word 0x52F6; imm 0x0100 → error, err_code 1, no mem_we ever asserted.
- Three-word burst with idle gaps on in_valid, last on third → addresses base..base+2, correct 4-cycle spacing, word_count 3.
- Memory model flips bit 0 on readback → error, err_code 2, word_count 0, next start clears error.
- Overflow and abort:
  - base 0x3FF, two words (first not last) → 0x3FF written and verified, then error, err_code 3, word_count 1, no wrap to 0x000.
  - rst_n pulled low during WRITE → all outputs at reset values that cycle; start ignored while busy.
